// File: rtl/regfile_writeback.sv
// Register file write-port arbiter: merges in-order pipeline results with buffered
// long-latency LSU results, tracks busy destinations and forwards the committing write.
module regfile_writeback #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned REG_COUNT      = 32,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      pipe_valid,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_rd,
  input  logic [XLEN-1:0]           pipe_data,
  output logic                      pipe_stall,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [XLEN-1:0]           lsu_data,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      rs1_fwd,
  output logic                      rs2_fwd,
  output logic [XLEN-1:0]           fwd_data,
  output logic                      wr_en,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr,
  output logic [XLEN-1:0]           wdata
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [REG_ADDR_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]           fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [STV_W-1:0]          starve_cnt;
  logic [REG_COUNT-1:0]      busy;
  logic [REG_COUNT-1:0]      busy_set;
  logic [REG_COUNT-1:0]      busy_clr;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      push;
  logic                      pop;
  logic [REG_ADDR_WIDTH-1:0] head_rd;
  logic [XLEN-1:0]           head_data;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign lsu_ready  = aresetn & ~fifo_full;
  assign push       = lsu_valid & lsu_ready;
  assign pipe_stall = (starve_cnt == STV_W'(STARVE_LIMIT));
  // A starved head preempts the pipe; otherwise the FIFO only drains into idle pipe slots.
  assign pop        = ~fifo_empty & (pipe_stall | ~pipe_valid);
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  assign rs1_busy = (rs1_addr != '0) & busy[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) & busy[rs2_addr];
  assign rs1_fwd  = wr_en & (rs1_addr == wr_addr) & (rs1_addr != '0);
  assign rs2_fwd  = wr_en & (rs2_addr == wr_addr) & (rs2_addr != '0);
  assign fwd_data = wdata;

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue_valid && (issue_rd != '0)) busy_set = REG_COUNT'(1) << issue_rd;
    if (pop) busy_clr = REG_COUNT'(1) << head_rd;
  end

  // Storage has no reset; occupancy is governed entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= lsu_rd;
      fifo_data[wr_ptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      busy       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wdata      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (fifo_empty || pop)
        starve_cnt <= '0;
      else if (starve_cnt != STV_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + STV_W'(1);

      busy <= (busy & ~busy_clr) | busy_set;

      if (pop) begin
        wr_en   <= (head_rd != '0);
        wr_addr <= head_rd;
        wdata   <= head_data;
      end else if (pipe_valid) begin
        wr_en   <= (pipe_rd != '0);
        wr_addr <= pipe_rd;
        wdata   <= pipe_data;
      end else begin
        wr_en   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: hand-computed expectations for writeback,
// x0 handling, scoreboard, FIFO backpressure, starvation and mid-operation reset.
module tb_regfile_writeback;

  logic        clk;
  logic        aresetn;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rs1_fwd;
  logic        rs2_fwd;
  logic [31:0] fwd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  regfile_writeback #(
    .XLEN(32),
    .REG_ADDR_WIDTH(5),
    .REG_COUNT(32),
    .FIFO_DEPTH(2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .fwd_data(fwd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wdata(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn = 1'b0; pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_lsu_ready", 32'(lsu_ready), 0);
    chk("rst_pipe_stall", 32'(pipe_stall), 0);
    tick(); tick();
    aresetn = 1'b1;
    #1;
    chk("post_rst_lsu_ready", 32'(lsu_ready), 1);

    // Pipeline write with forwarding
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    tick();
    pipe_valid = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd6;
    #1;
    chk("pipe_wr_en", 32'(wr_en), 1);
    chk("pipe_wr_addr", 32'(wr_addr), 5);
    chk("pipe_wdata", wdata, 32'hDEADBEEF);
    chk("pipe_rs1_fwd", 32'(rs1_fwd), 1);
    chk("pipe_rs2_fwd", 32'(rs2_fwd), 0);
    chk("pipe_fwd_data", fwd_data, 32'hDEADBEEF);
    tick();
    chk("idle_wr_en", 32'(wr_en), 0);
    chk("idle_rs1_fwd", 32'(rs1_fwd), 0);

    // x0 writes from both sources are consumed silently
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h1234;
    tick();
    pipe_valid = 1'b0;
    chk("x0_pipe_wr_en", 32'(wr_en), 0);
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h77;
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("x0_lsu_ready", 32'(lsu_ready), 1);
    tick();
    chk("x0_lsu_wr_en", 32'(wr_en), 0);
    chk("x0_lsu_wdata", wdata, 32'h77);
    tick();
    chk("x0_fifo_drained", 32'(wr_en), 0);

    // Scoreboard: issue rd=7, LSU returns rd=7
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0; rs1_addr = 5'd7;
    #1;
    chk("sb_busy_set", 32'(rs1_busy), 1);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h55;
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("sb_busy_pop_cycle", 32'(rs1_busy), 1);
    tick();
    chk("sb_wr_en", 32'(wr_en), 1);
    chk("sb_wr_addr", 32'(wr_addr), 7);
    chk("sb_wdata", wdata, 32'h55);
    chk("sb_busy_clr", 32'(rs1_busy), 0);
    chk("sb_rs1_fwd", 32'(rs1_fwd), 1);

    // FIFO fills while the pipe owns the port
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA0;
    #1;
    chk("fill_ready0", 32'(lsu_ready), 1);
    tick();
    lsu_rd = 5'd11; lsu_data = 32'hA1;
    #1;
    chk("fill_ready1", 32'(lsu_ready), 1);
    tick();
    lsu_rd = 5'd12; lsu_data = 32'hA2;
    #1;
    chk("fill_ready_full", 32'(lsu_ready), 0);
    chk("fill_no_stall", 32'(pipe_stall), 0);
    tick();
    chk("fill_ready_still_full", 32'(lsu_ready), 0);
    chk("fill_pipe_addr", 32'(wr_addr), 1);
    chk("fill_pipe_en", 32'(wr_en), 1);
    lsu_valid = 1'b0; pipe_valid = 1'b0;
    tick();
    chk("drain0_addr", 32'(wr_addr), 10);
    chk("drain0_data", wdata, 32'hA0);
    tick();
    chk("drain1_addr", 32'(wr_addr), 11);
    chk("drain1_data", wdata, 32'hA1);
    tick();
    chk("drain_rejected", 32'(wr_en), 0);
    chk("drain_ready", 32'(lsu_ready), 1);

    // Starvation: head waits STARVE_LIMIT cycles, then preempts the pipe
    pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h22;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    tick();
    lsu_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("starve_c%0d_stall", c), 32'(pipe_stall), 0);
      chk($sformatf("starve_c%0d_addr", c), 32'(wr_addr), 2);
      tick();
    end
    chk("starve_c5_stall", 32'(pipe_stall), 1);
    tick();
    chk("starve_c6_addr", 32'(wr_addr), 9);
    chk("starve_c6_data", wdata, 32'h99);
    chk("starve_c6_en", 32'(wr_en), 1);
    chk("starve_c6_stall", 32'(pipe_stall), 0);
    tick();
    chk("starve_c7_addr", 32'(wr_addr), 2);
    pipe_valid = 1'b0;
    tick();

    // Same-cycle set and clear of rd=3: set wins
    issue_valid = 1'b1; issue_rd = 5'd3;
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
    tick();
    lsu_valid = 1'b0;
    tick();
    issue_valid = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd0;
    #1;
    chk("setwin_addr", 32'(wr_addr), 3);
    chk("setwin_en", 32'(wr_en), 1);
    chk("setwin_busy", 32'(rs1_busy), 1);
    chk("x0_busy", 32'(rs2_busy), 0);

    // Reset with two buffered entries
    pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h44;
    issue_valid = 1'b1; issue_rd = 5'd13;
    lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'hD0;
    tick();
    issue_valid = 1'b0; lsu_rd = 5'd14; lsu_data = 32'hD1;
    tick();
    lsu_valid = 1'b0; rs1_addr = 5'd13;
    #1;
    chk("prerst_full", 32'(lsu_ready), 0);
    chk("prerst_busy", 32'(rs1_busy), 1);
    aresetn = 1'b0; pipe_valid = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_wr_addr", 32'(wr_addr), 0);
    chk("midrst_wdata", wdata, 0);
    chk("midrst_ready", 32'(lsu_ready), 0);
    chk("midrst_stall", 32'(pipe_stall), 0);
    chk("midrst_busy", 32'(rs1_busy), 0);
    tick(); tick();
    aresetn = 1'b1;
    #1;
    chk("postrst_ready", 32'(lsu_ready), 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("postrst_no_wr%0d", c), 32'(wr_en), 0);
      chk($sformatf("postrst_busy%0d", c), 32'(rs1_busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
